// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider plus wrapping column/line counters, with
// sync, visible-window, pixel-enable and end-of-frame decodes for the pixel pipeline.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds may equal 1024, so these decodes use an extra bit.
  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] H_START_W = 11'(H_ACT_START);
  localparam logic [10:0] H_END_W   = 11'(H_ACT_END);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] V_START_W = 11'(V_ACT_START);
  localparam logic [10:0] V_END_W   = 11'(V_ACT_END);

  if (CLK_DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024 ||
      H_SYNC < 1 || !(H_SYNC < H_ACT_START && H_ACT_START < H_ACT_END && H_ACT_END <= H_TOTAL) ||
      V_SYNC < 1 || !(V_SYNC < V_ACT_START && V_ACT_START < V_ACT_END && V_ACT_END <= V_TOTAL))
  begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DIV_W-1:0] div;
  logic             line_end;
  logic             frame_end;
  logic [10:0]      h_wide;
  logic [10:0]      v_wide;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the async clear also makes all decodes idle while reset is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (div >= DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign pix_en = (div == DIV_LAST);

  // ">=" rather than "==" so a corrupted out-of-range count recovers on the next pixel.
  assign line_end  = (hCount >= H_LAST);
  assign frame_end = (vCount >= V_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        hCount <= '0;
        vCount <= frame_end ? 10'd0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  assign h_wide = {1'b0, hCount};
  assign v_wide = {1'b0, vCount};

  assign hSync  = (h_wide >= H_SYNC_W);
  assign vSync  = (v_wide >= V_SYNC_W);
  assign bright = (h_wide >= H_START_W) && (h_wide < H_END_W) &&
                  (v_wide >= V_START_W) && (v_wide < V_END_W);

  assign frame_tick = pix_en && (hCount == H_LAST) && (vCount == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a full-size instance for line timing and a
// shrunken instance whose whole frame fits in a short run. Expectations are hand-computed.
module tb_vga_timing_gen;

  typedef enum logic [2:0] {K_SNAP, K_D_HLOW, K_D_VLOW, K_S_FTICK, K_S_VLOW} kind_e;

  typedef struct packed {
    int    k;      // posedges since reset release; -1 means "sampled while in reset"
    kind_e kind;
    int    dut;    // 0 = full-size instance, 1 = small instance
    int    h;
    int    v;
    int    hs;
    int    vs;
    int    br;
    int    pe;
    int    ft;
    int    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  exp_t q[$];

  logic [9:0] d_h, d_v, s_h, s_v;
  logic d_hs, d_vs, d_br, d_pe, d_ft;
  logic s_hs, s_vs, s_br, s_pe, s_ft;

  vga_timing_gen dut_full (
    .clk(clk), .reset_n(reset_n), .hCount(d_h), .vCount(d_v), .hSync(d_hs),
    .vSync(d_vs), .bright(d_br), .pix_en(d_pe), .frame_tick(d_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(16), .H_SYNC(2), .H_ACT_START(4), .H_ACT_END(12),
    .V_TOTAL(10), .V_SYNC(1), .V_ACT_START(3), .V_ACT_END(8)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .hCount(s_h), .vCount(s_v), .hSync(s_hs),
    .vSync(s_vs), .bright(s_br), .pix_en(s_pe), .frame_tick(s_ft)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_snap(input int dut, input int kk, input int h, input int v, input int hs,
                           input int vs, input int br, input int pe, input int ft);
    exp_t e;
    e = '{k: kk, kind: K_SNAP, dut: dut, h: h, v: v, hs: hs, vs: vs, br: br, pe: pe, ft: ft, cnt: 0};
    q.push_back(e);
  endtask

  task automatic push_cnt(input kind_e kind, input int kk, input int cnt);
    exp_t e;
    e = '{k: kk, kind: kind, dut: 0, h: 0, v: 0, hs: 0, vs: 0, br: 0, pe: 0, ft: 0, cnt: cnt};
    q.push_back(e);
  endtask

  task automatic push_reset_state();
    push_snap(0, -1, 0, 0, 0, 0, 0, 0, 0);
    push_snap(1, -1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_release_start();
    push_snap(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_snap(1, 0, 0, 0, 0, 0, 0, 0, 0);
    push_snap(0, 1, 0, 0, 0, 0, 0, 0, 0);
    push_snap(1, 1, 0, 0, 0, 0, 0, 1, 0);
    push_snap(0, 2, 0, 0, 0, 0, 0, 0, 0);
    push_snap(0, 3, 0, 0, 0, 0, 0, 1, 0);
    push_snap(0, 4, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: measures running counts and retires every expectation whose sample point arrives.
  initial begin : monitor
    int   d_hlow, d_vlow, s_ftick, s_vlow;
    exp_t e;
    string tag;
    d_hlow = 0; d_vlow = 0; s_ftick = 0; s_vlow = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (d_hs === 1'b0) d_hlow++;
        if (d_vs === 1'b0) d_vlow++;
        if (s_ft === 1'b1) s_ftick++;
        if (s_vs === 1'b0) s_vlow++;
      end else begin
        d_hlow = 0; d_vlow = 0; s_ftick = 0; s_vlow = 0;
      end
      while (q.size() > 0) begin
        e = q[0];
        if ((e.k < 0) ? !reset_n : (reset_n && e.k == k)) begin
          void'(q.pop_front());
          tag = $sformatf("%s k=%0d", (e.dut == 0) ? "full" : "small", e.k);
          case (e.kind)
            K_SNAP: begin
              if (e.dut == 0) begin
                check({tag, " hCount"}, 32'(d_h), e.h);
                check({tag, " vCount"}, 32'(d_v), e.v);
                check({tag, " hSync"},  32'(d_hs), e.hs);
                check({tag, " vSync"},  32'(d_vs), e.vs);
                check({tag, " bright"}, 32'(d_br), e.br);
                check({tag, " pix_en"}, 32'(d_pe), e.pe);
                check({tag, " frame_tick"}, 32'(d_ft), e.ft);
              end else begin
                check({tag, " hCount"}, 32'(s_h), e.h);
                check({tag, " vCount"}, 32'(s_v), e.v);
                check({tag, " hSync"},  32'(s_hs), e.hs);
                check({tag, " vSync"},  32'(s_vs), e.vs);
                check({tag, " bright"}, 32'(s_br), e.br);
                check({tag, " pix_en"}, 32'(s_pe), e.pe);
                check({tag, " frame_tick"}, 32'(s_ft), e.ft);
              end
            end
            K_D_HLOW:  check($sformatf("full hSync low clks to k=%0d", e.k), d_hlow, e.cnt);
            K_D_VLOW:  check($sformatf("full vSync low clks to k=%0d", e.k), d_vlow, e.cnt);
            K_S_FTICK: check($sformatf("small frame_tick count to k=%0d", e.k), s_ftick, e.cnt);
            default:   check($sformatf("small vSync low clks to k=%0d", e.k), s_vlow, e.cnt);
          endcase
        end else if (reset_n && e.k >= 0 && e.k < k) begin
          void'(q.pop_front());
          check("sample point skipped", k, e.k);
        end else begin
          break;
        end
      end
      if (done) begin
        while (q.size() > 0) begin
          e = q.pop_front();
          check("expectation never reached", 32'(k), 32'(e.k));
        end
      end
    end
  end

  initial begin : stimulus
    push_reset_state();
    repeat (5) @(posedge clk);
    #2;
    push_release_start();
    push_snap(1,    7,   3, 0, 1, 0, 0, 1, 0);
    push_snap(1,   80,   8, 2, 1, 1, 0, 0, 0);
    push_snap(1,  103,   3, 3, 1, 1, 0, 1, 0);
    push_snap(1,  104,   4, 3, 1, 1, 1, 0, 0);
    push_snap(1,  119,  11, 3, 1, 1, 1, 1, 0);
    push_snap(1,  120,  12, 3, 1, 1, 0, 0, 0);
    push_snap(1,  240,   8, 7, 1, 1, 1, 0, 0);
    push_snap(1,  272,   8, 8, 1, 1, 0, 0, 0);
    push_snap(1,  318,  15, 9, 1, 1, 0, 0, 0);
    push_snap(1,  319,  15, 9, 1, 1, 0, 1, 1);
    push_snap(1,  320,   0, 0, 0, 0, 0, 0, 0);
    push_snap(0,  383,  95, 0, 0, 0, 0, 1, 0);
    push_snap(0,  384,  96, 0, 1, 0, 0, 0, 0);
    push_snap(1,  639,  15, 9, 1, 1, 0, 1, 1);
    push_cnt(K_S_FTICK, 639, 2);
    push_cnt(K_S_VLOW,  639, 64);
    push_snap(0, 3199, 799, 0, 1, 0, 0, 1, 0);
    push_cnt(K_D_HLOW, 3199, 384);
    push_snap(0, 3200,   0, 1, 0, 0, 0, 0, 0);
    push_snap(0, 6399, 799, 1, 1, 0, 0, 1, 0);
    push_cnt(K_D_VLOW, 6399, 6400);
    push_snap(0, 6400,   0, 2, 0, 1, 0, 0, 0);
    push_snap(0, 6505,  26, 2, 0, 1, 0, 0, 0);
    push_snap(1, 6505,   4, 3, 1, 1, 1, 1, 0);
    reset_n = 1'b1;

    // Reset lands 1 ns after an edge; the monitor samples before the following edge.
    repeat (6506) @(posedge clk);
    #1;
    push_reset_state();
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    push_release_start();
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
